// File: rtl/regfile_wb_arbiter_if.sv
// ============================================================================
// regfile_wb_arbiter_if : write-port sharing bus (pipeline WB, mult/div, RF)
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                   pipe_wr_en;
  logic [ADDR_W-1:0]      pipe_wr_addr;
  logic [DATA_W-1:0]      pipe_wr_data;
  logic                   md_valid;
  logic                   md_ready;
  logic [ADDR_W-1:0]      md_addr;
  logic [DATA_W-1:0]      md_data;
  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic                   stall_req;
  logic [2**ADDR_W-1:0]   pending_mask;

  modport master (
    output pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    output md_valid, md_addr, md_data,
    input  md_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  stall_req, pending_mask
  );

  modport slave (
    input  pipe_wr_en, pipe_wr_addr, pipe_wr_data,
    input  md_valid, md_addr, md_data,
    output md_ready,
    output rf_we, rf_waddr, rf_wdata,
    output stall_req, pending_mask
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// regfile_wb_arbiter : RF write-port arbiter, pipeline first, mult/div FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam int NREG  = 2**ADDR_W;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

  logic [ADDR_W-1:0] addr_q [BUF_DEPTH];
  logic [DATA_W-1:0] data_q [BUF_DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [CNT_W-1:0]  count_q,   count_d;
  logic [STV_W-1:0]  starve_q,  starve_d;
  logic              stall_q,   stall_d;

  logic              w_empty;
  logic              w_full;
  logic              w_pipe_win;
  logic              w_push;
  logic              w_pop;
  logic [NREG-1:0]   w_pending;

  assign w_empty    = (count_q == '0);
  assign w_full     = (count_q == DEPTH_C);
  // A pipe write to r0 is a no-op and leaves the port free for the FIFO.
  assign w_pipe_win = bus.pipe_wr_en && (bus.pipe_wr_addr != '0);
  assign w_pop      = !w_pipe_win && !w_empty;
  // Ready comes from registered fullness only: a same-cycle pop never frees a slot.
  assign w_push     = bus.md_valid && !w_full && (bus.md_addr != '0);

  assign bus.md_ready     = !rst && !w_full;
  assign bus.rf_we        = !rst && (w_pipe_win || !w_empty);
  assign bus.rf_waddr     = w_pipe_win ? bus.pipe_wr_addr : addr_q[rd_ptr_q];
  assign bus.rf_wdata     = w_pipe_win ? bus.pipe_wr_data : data_q[rd_ptr_q];
  assign bus.stall_req    = stall_q;
  assign bus.pending_mask = w_pending;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    stall_d  = stall_q;

    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (w_empty || w_pop) begin
      starve_d = '0;
    end else if (starve_q != LIMIT_C) begin
      starve_d = starve_q + STV_W'(1);
    end

    // Stall tracks saturation, so it drops on the same edge the counter clears.
    stall_d = (starve_d == LIMIT_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  for (genvar i = 0; i < BUF_DEPTH; i++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end else if (w_push && (wr_ptr_q == PTR_W'(i))) begin
        addr_q[i] <= bus.md_addr;
        data_q[i] <= bus.md_data;
      end
    end
  end

  // Entry k positions past the read pointer is live when k < count.
  always_comb begin
    logic [PTR_W-1:0] idx;
    w_pending = '0;
    idx       = '0;
    for (int k = 0; k < BUF_DEPTH; k++) begin
      idx = rd_ptr_q + PTR_W'(k);
      if (CNT_W'(k) < count_q) begin
        w_pending[addr_q[idx]] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two sources: the in-order pipeline writeback stage and the multi-cycle multiply/divide unit.
- The pipeline has fixed priority. Mult/div results are buffered in a small in-order FIFO and drained when the port is idle.
- A starvation counter raises a stall request so the pipeline inserts a writeback bubble.
- A pending-write mask is exported to the hazard unit.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers)
- BUF_DEPTH, 2, mult/div result FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 4, consecutive denied cycles before stall_req asserts (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- pipe_wr_en  in  1  pipeline WB write request; never back-pressured
- pipe_wr_addr  in  ADDR_W  pipeline destination register
- pipe_wr_data  in  DATA_W  pipeline write data
- md_valid  in  1  mult/div result valid
- md_ready  out  1  FIFO can accept a result
- md_addr  in  ADDR_W  mult/div destination register
- md_data  in  DATA_W  mult/div result
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write index
- rf_wdata  out  DATA_W  register file write data
- stall_req  out  1  request for a one-cycle pipeline WB bubble
- pending_mask  out  2**ADDR_W  bit i set while any FIFO entry targets register i

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset clears the FIFO, read/write pointers, count, starve counter and stall_req. Entries in flight are discarded with no write issued.
- Output values in and after reset: while rst=1, md_ready=0 and rf_we=0. After rst is released: md_ready=1, rf_we=0 unless pipe_wr_en, pending_mask=0, stall_req=0.
- Enqueue: md_ready = !full, taken from registered state. A handshake occurs when md_valid && md_ready at a clock edge.
- md_addr==0 is accepted but not stored. No pending bit is set and no write is issued.
- A pop in the same cycle does NOT open space for a push while full. md_ready stays 0 until the cycle after the pop.
- Arbitration is combinational from the current inputs and FIFO head.
  - Priority 1: pipe_wr_en && pipe_wr_addr!=0 drives rf_* from the pipe inputs. The FIFO is not popped.
  - Priority 2: otherwise, if the FIFO is non-empty, rf_* is driven from the FIFO head and the FIFO pops at the edge.
  - Otherwise rf_we=0. rf_waddr/rf_wdata hold the head value (don't-care).
- A pipe write to register 0 is dropped and does not occupy the port, so the FIFO may drain in that cycle.
- Latency: an md result accepted at edge N can be written at the earliest during cycle N+1. There is no same-cycle bypass.
- FIFO order is strict in-order. Two entries with the same address are both written, oldest first, so the last result wins.
- pending_mask is the OR of one-hot decodes of all valid entries, computed combinationally from registered state. A bit clears the cycle after its last entry pops.
- The arbiter never reorders a pipe write against a buffered write to the same register. The hazard unit uses pending_mask to stall such instructions.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs, saturating at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
- stall_req is registered. It is set at the edge where the counter reaches STARVE_LIMIT, and cleared at the edge of the next pop or on empty.
- Pipeline contract: pipe_wr_en=0 in any cycle where stall_req=1. If the contract is violated, the pipe still wins (no data loss) and stall_req stays high.
- Simultaneous push and pop when not full: count is unchanged and pointers advance. Pointers wrap modulo BUF_DEPTH.

Test Plan:
- Reset release, idle -> md_ready=1, rf_we=0, stall_req=0, pending_mask=0; assert rst mid-operation with 2 entries queued -> FIFO empty, no writes afterwards.
- Pipe write r5=0x11 while md pushes r7=0xAA in the same cycle -> rf writes r5=0x11 that cycle; r7=0xAA next idle cycle; pending_mask bit7 high for exactly the cycles in between.
- Push r3=1 then r3=2 back-to-back with pipe busy writing r9 -> md_ready=0 after 2 pushes; once the pipe goes idle, writes r3=1 then r3=2 in order; bit3 clears after the second pop.
- Continuous pipe writes with 1 entry queued, STARVE_LIMIT=4 -> stall_req high after 4 denied cycles; bench drops pipe_wr_en -> entry written that cycle; stall_req low next cycle.
- md push to r0 and pipe write to r0 -> no rf_we from either, no pending bit; a queued entry drains in the pipe's r0 cycle.
- Full FIFO, pop and md_valid in the same cycle -> no accept that cycle; accept on the next cycle; the pointer wrap yields correct order over 6 pushes.
